// File: rtl/flatten_stream_if.sv
// Stream bundle for flatten_stream: tensor capture handshake in, flattened element stream out.
// The slave modport is the block's view; the master modport is the producer/consumer side.
interface flatten_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAP_SIZE   = 2,
    parameter int CHANNELS   = 4
);
    localparam int N  = CHANNELS * MAP_SIZE * MAP_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_tensor;
    logic                    in_order;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [IW-1:0]           out_index;
    logic                    out_last;

    modport slave (
        input  in_valid, in_tensor, in_order, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

    modport master (
        output in_valid, in_tensor, in_order, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/flatten_stream.sv
// Captures one pooled tensor and streams its elements one per handshake,
// in channel-major or pixel-major order chosen at capture time.
module flatten_stream #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAP_SIZE   = 2,
    parameter  int CHANNELS   = 4,
    localparam int N          = CHANNELS * MAP_SIZE * MAP_SIZE,
    localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    flatten_stream_if.slave  strm
);
    localparam int          PIX  = MAP_SIZE * MAP_SIZE;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                         state, state_nx;
    logic [IW-1:0]                  cnt, cnt_nx;
    logic                           order;
    logic                           capture;
    logic                           at_last;
    logic [IW-1:0]                  addr;
    logic [N-1:0][DATA_WIDTH-1:0]   tens;

    assign at_last = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            order <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (capture) order <= strm.in_order;
        end
    end

    // Buffer is never cleared; out_data is gated by state so stale contents never leak.
    always_ff @(posedge clk) begin
        if (capture) tens <= strm.in_tensor;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && strm.in_valid) begin
                    capture  = 1'b1;
                    state_nx = STREAM;
                    cnt_nx   = '0;
                end
            end
            STREAM: begin
                if (strm.out_ready) begin
                    if (at_last) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                // A beat handshaking alongside flush has already completed; just idle.
                if (flush) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Channel-major order walks the packed layout linearly; pixel-major interleaves channels.
    always_comb begin
        addr = cnt;
        if (order)
            addr = IW'((int'(cnt) % CHANNELS) * PIX + int'(cnt) / CHANNELS);
    end

    assign strm.in_ready  = (state == IDLE);
    assign strm.out_valid = (state == STREAM);
    assign strm.out_index = cnt;
    assign strm.out_last  = (state == STREAM) && at_last;
    assign strm.out_data  = (state == STREAM) ? tens[addr] : '0;
endmodule

// File: tb/tb_flatten_stream.sv
// Scoreboard bench for flatten_stream: expected beats queued at capture, checked on each handshake.
module tb_flatten_stream;
    localparam int DW = 8;
    localparam int MS = 2;
    localparam int CH = 2;
    localparam int N  = CH * MS * MS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;

    flatten_stream_if #(.DATA_WIDTH(DW), .MAP_SIZE(MS), .CHANNELS(CH)) strm ();

    flatten_stream #(.DATA_WIDTH(DW), .MAP_SIZE(MS), .CHANNELS(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .strm  (strm)
    );

    exp_t q[$];
    int   n_vec;
    int   n_err;
    int   n_pop;
    logic stalled;
    exp_t saved;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] mk(input logic [7:0] base);
        logic [N*DW-1:0] t;
        t = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < MS; r++)
                for (int k = 0; k < MS; k++)
                    t[((c*MS+r)*MS+k)*DW +: DW] = base + 8'(16*c + 2*r + k + 1);
        return t;
    endfunction

    function automatic logic [DW-1:0] elem(input logic [N*DW-1:0] t, input logic ord, input int i);
        int c, r, k;
        if (!ord) begin
            c = i / (MS*MS); r = (i / MS) % MS; k = i % MS;
        end else begin
            c = i % CH; r = (i / CH) / MS; k = (i / CH) % MS;
        end
        return t[((c*MS+r)*MS+k)*DW +: DW];
    endfunction

    task automatic push_exp(input logic [N*DW-1:0] t, input logic ord);
        for (int i = 0; i < N; i++)
            q.push_back('{data: elem(t, ord, i), idx: IW'(i), last: (i == N-1)});
    endtask

    // Offer a tensor for one cycle; caller guarantees the block is idle.
    task automatic offer(input logic [N*DW-1:0] t, input logic ord);
        push_exp(t, ord);
        strm.in_tensor = t;
        strm.in_order  = ord;
        strm.in_valid  = 1'b1;
        @(posedge clk); #1;
        strm.in_valid  = 1'b0;
        chk("latency_valid", 32'(strm.out_valid), 1);
        chk("first_index", 32'(strm.out_index), 0);
    endtask

    task automatic drain(input int budget, input logic rnd, output int cyc);
        cyc = 0;
        while (q.size() != 0 && cyc < budget) begin
            if (rnd) strm.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        strm.out_ready = 1'b1;
        chk("drain_left", 32'(q.size()), 0);
        chk("end_in_ready", 32'(strm.in_ready), 1);
        chk("end_out_valid", 32'(strm.out_valid), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stalled <= 1'b0;
        end else begin
            if (stalled && strm.out_valid)
                chk("stall_hold", 32'({strm.out_data, strm.out_index, strm.out_last}), 32'(saved));
            if (strm.out_valid && strm.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("data", 32'(strm.out_data), 32'(q[0].data));
                    chk("index", 32'(strm.out_index), 32'(q[0].idx));
                    chk("last", 32'(strm.out_last), 32'(q[0].last));
                    void'(q.pop_front());
                    n_pop <= n_pop + 1;
                end
            end
            stalled <= strm.out_valid && !strm.out_ready;
            saved   <= '{data: strm.out_data, idx: strm.out_index, last: strm.out_last};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int idle;
        int guard;
        n_vec = 0; n_err = 0; n_pop = 0;
        reset = 1'b1; flush = 1'b0;
        strm.in_valid = 1'b0; strm.in_tensor = '0; strm.in_order = 1'b0; strm.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(strm.in_ready), 1);
        chk("rst_out_valid", 32'(strm.out_valid), 0);
        chk("rst_out_index", 32'(strm.out_index), 0);
        chk("rst_out_last", 32'(strm.out_last), 0);
        chk("rst_out_data", 32'(strm.out_data), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // channel-major, consumer always ready
        offer(mk(8'h00), 1'b0);
        drain(50, 1'b0, cyc);
        chk("cm_cycles", 32'(cyc), 8);

        // pixel-major
        offer(mk(8'h00), 1'b1);
        drain(50, 1'b0, cyc);
        chk("pm_cycles", 32'(cyc), 8);

        // random backpressure with an ignored mid-stream offer
        offer(mk(8'h00), 1'b0);
        strm.out_ready = 1'b0;
        strm.in_tensor = mk(8'h60);
        strm.in_valid  = 1'b1;
        chk("stream_in_ready", 32'(strm.in_ready), 0);
        @(posedge clk); #1;
        strm.in_valid  = 1'b0;
        drain(400, 1'b1, cyc);

        // flush after three accepted beats; beat in the flush cycle still completes
        offer(mk(8'h20), 1'b0);
        guard = 0;
        while (n_pop % N != 3 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        chk("flush_reach", 32'(n_pop % N), 3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", 32'(strm.out_valid), 0);
        chk("flush_in_ready", 32'(strm.in_ready), 1);
        chk("flush_beats", 32'(q.size()), 4);
        q.delete();
        flush = 1'b1; strm.in_valid = 1'b1; strm.in_tensor = mk(8'h80);
        @(posedge clk); #1;
        flush = 1'b0; strm.in_valid = 1'b0;
        chk("flush_win_valid", 32'(strm.out_valid), 0);
        @(posedge clk); #1;
        chk("flush_win_valid2", 32'(strm.out_valid), 0);
        offer(mk(8'h30), 1'b1);
        drain(50, 1'b0, cyc);

        // asynchronous reset mid-stream
        offer(mk(8'h00), 1'b0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(strm.out_valid), 0);
        chk("arst_out_index", 32'(strm.out_index), 0);
        chk("arst_in_ready", 32'(strm.in_ready), 1);
        q.delete();
        @(posedge clk); #1 reset = 1'b0;
        offer(mk(8'h50), 1'b0);
        drain(50, 1'b0, cyc);

        // back-to-back tensors with in_valid held high
        push_exp(mk(8'h00), 1'b0);
        strm.in_tensor = mk(8'h00); strm.in_order = 1'b0; strm.in_valid = 1'b1;
        @(posedge clk); #1;
        push_exp(mk(8'h40), 1'b0);
        strm.in_tensor = mk(8'h40);
        idle = 0; guard = 0;
        while (q.size() != 0 && guard < 60) begin
            if (!strm.out_valid) idle++;
            if (idle > 0 && strm.out_valid) strm.in_valid = 1'b0;
            @(posedge clk); #1; guard++;
        end
        strm.in_valid = 1'b0;
        chk("b2b_idle_cycles", 32'(idle), 1);
        chk("b2b_left", 32'(q.size()), 0);
        chk("b2b_in_ready", 32'(strm.in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
